cpu: RTL and testbench
======================

// Module: cpu
// PURPOSE
// - Single-cycle 8-bit execution unit: decodes one 19-bit instruction word per clock and
//   performs an ALU operation on two immediate 8-bit operands.
// - Produces a registered 8-bit result plus carry/zero flags.
// - Leaf compute block; the upstream fetch/sequencer logic drives opcode every cycle.
// PARAMETERS
// - DATA_W   8   operand/result width (only 8 is verified)
// - OP_W     3   operation-field width
// PORTS
// - clk      in   1   rising-edge clock; the single clock domain
// - rst_n    in   1   reset, synchronous, active-low
// - opcode   in   19  instruction word: [18:16]=op, [15:8]=A, [7:0]=B
// - result   out  8   registered ALU result
// - carry    out  1   registered carry/borrow/shift-out flag
// - zero     out  1   registered flag, 1 when the result register is 0x00
// BEHAVIOUR
// - Reset: synchronous, active-low. While rst_n=0 at a rising edge: result=0x00,
//   carry=0, zero=1. opcode is ignored during reset.
// - Latency: 1 cycle. The opcode sampled at edge N is reflected on result/carry/zero
//   after edge N. No handshake; a new instruction is accepted every cycle.
// - Operation table (A=opcode[15:8], B=opcode[7:0]; all unsigned, results mod 256):
//   - 000 NOP: result, carry and zero hold their previous values.
//   - 001 ADD: result=A+B; carry=bit 8 of the 9-bit sum.
//   - 010 SUB: result=A-B; carry=1 when A<B (borrow).
//   - 011 AND: result=A&B; carry=0.
//   - 100 OR:  result=A|B; carry=0.
//   - 101 XOR: result=A^B; carry=0.
//   - 110 SHL: result=A<<B[2:0]; carry=last bit shifted out (0 when B[2:0]=0).
//   - 111 SHR: logical, result=A>>B[2:0], zero-fill; carry=last bit shifted out
//     (0 when B[2:0]=0).
// - Shift amount uses only B[2:0]; B[7:3] is ignored for SHL and SHR.
// - zero is computed from the new result value for every non-NOP operation.
// - No internal state beyond the three output registers. No X-propagation:
//   every op code is defined.
// - Reset asserted in the same cycle as any op: reset wins.
// STRUCTURE
// - Shared package cpu_pkg: localparams OP_NOP..OP_SHR (3-bit codes above), the field
//   bit positions (OP_MSB=18, A_MSB=15, B_MSB=7) and DATA_W.
// - One combinational sub-module cpu_alu(op, a, b -> y, c). The top level cpu
//   holds instruction field slicing, NOP hold logic, zero generation and the
//   reset/output registers.
// TESTING
// - Reset: hold rst_n=0 for 2 clocks with opcode=ADD 0x23,0x14 -> result=0x00,
//   carry=0, zero=1.
// - Operands A=0x00, B=0xFF, ops 001..111, one per clock -> result FF,01,00,FF,FF,00,00;
//   carry 0,1,0,0,0,0,0; zero 0,0,1,0,0,1,1.
// - Operands A=0x23, B=0x14, ops 001..111 -> result 37,0F,00,37,37,30,02;
//   carry 0,0,0,0,0,0,0; zero set only for AND.
// - Carry edges: ADD 0xFF+0x01 -> result=0x00, carry=1, zero=1.
//   SHL 0x81 by 1 -> result=0x02, carry=1. SHR 0x01 by 1 -> result=0x00, carry=1, zero=1.
// - NOP hold: ADD 0x10+0x05, then NOP with random A/B for 3 cycles -> result stays 0x15,
//   carry=0, zero=0.
// - Back-to-back and mid-stream reset: alternating ops every clock give exactly 1-cycle
//   latency; pulsing rst_n low for one clock mid-stream clears the outputs on that edge,
//   and the next edge resumes normal operation.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants for the 8-bit execution unit
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;

  // Instruction field MSB positions: [18:16]=op, [15:8]=A, [7:0]=B
  localparam int OP_MSB = 18;
  localparam int A_MSB  = 15;
  localparam int B_MSB  = 7;
  localparam int INSN_W = OP_MSB + 1;

  localparam logic [OP_W-1:0] OP_NOP = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD = 3'b001;
  localparam logic [OP_W-1:0] OP_SUB = 3'b010;
  localparam logic [OP_W-1:0] OP_AND = 3'b011;
  localparam logic [OP_W-1:0] OP_OR  = 3'b100;
  localparam logic [OP_W-1:0] OP_XOR = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL = 3'b110;
  localparam logic [OP_W-1:0] OP_SHR = 3'b111;

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational ALU producing result and carry/borrow/shift-out
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              c
);

  logic [2:0] sh;
  assign sh = b[2:0];

  // Operation select; shifts use a 9-bit window so the carry is the last bit
  // pushed out, which naturally stays 0 for a zero shift amount.
  always_comb begin
    y = '0;
    c = 1'b0;
    unique case (op)
      OP_ADD: {c, y} = {1'b0, a} + {1'b0, b};
      OP_SUB: {c, y} = {1'b0, a} - {1'b0, b};
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SHL: {c, y} = {1'b0, a} << sh;
      OP_SHR: {y, c} = {a, 1'b0} >> sh;
      default: begin
        y = '0;
        c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cpu.sv
// rtl/cpu.sv - single-cycle execution unit with registered result and flags
module cpu
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INSN_W-1:0] opcode,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] alu_y;
  logic              alu_c;

  logic [DATA_W-1:0] result_q, result_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;

  assign op = opcode[OP_MSB -: OP_W];
  assign a  = opcode[A_MSB -: DATA_W];
  assign b  = opcode[B_MSB -: DATA_W];

  cpu_alu u_alu (
    .op (op),
    .a  (a),
    .b  (b),
    .y  (alu_y),
    .c  (alu_c)
  );

  // Next state: NOP holds all three registers, every other op loads the ALU output
  always_comb begin
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    if (op != OP_NOP) begin
      result_d = alu_y;
      carry_d  = alu_c;
      zero_d   = (alu_y == '0);
    end
  end

  // Output registers; reset takes priority over any instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - self-checking bench for cpu against an arithmetic reference model
module tb_cpu;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [18:0] opcode = '0;
  logic [7:0]  result;
  logic        carry;
  logic        zero;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] m_res = 8'h00;
  logic       m_c   = 1'b0;
  logic       m_z   = 1'b1;

  logic [7:0] t1_r [7] = '{8'hFF, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
  logic       t1_c [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       t1_z [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0] t2_r [7] = '{8'h37, 8'h0F, 8'h00, 8'h37, 8'h37, 8'h30, 8'h02};
  logic       t2_z [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  cpu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .opcode (opcode),
    .result (result),
    .carry  (carry),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation table
  task automatic model(input bit rst, input int op, input int a, input int b);
    int sh;
    int full;
    if (rst) begin
      m_res = 8'h00;
      m_c   = 1'b0;
      m_z   = 1'b1;
      return;
    end
    if (op == 0) return;
    sh = b % 8;
    case (op)
      1: begin full = a + b; m_res = 8'(full % 256); m_c = (full > 255); end
      2: begin m_res = 8'((a - b + 256) % 256); m_c = (a < b); end
      3: begin m_res = 8'(a & b); m_c = 1'b0; end
      4: begin m_res = 8'(a | b); m_c = 1'b0; end
      5: begin m_res = 8'(a ^ b); m_c = 1'b0; end
      6: begin
        full  = a * (1 << sh);
        m_res = 8'(full % 256);
        m_c   = (sh != 0) && ((full / 256) % 2 == 1);
      end
      default: begin
        m_res = 8'(a / (1 << sh));
        m_c   = (sh != 0) && ((a / (1 << (sh - 1))) % 2 == 1);
      end
    endcase
    m_z = (m_res == 8'h00);
  endtask

  // One clock: drive at negedge, sample 1 time unit after the rising edge
  task automatic step(input bit rst, input int op, input int a, input int b);
    @(negedge clk);
    rst_n  = !rst;
    opcode = {3'(op), 8'(a), 8'(b)};
    @(posedge clk);
    #1;
    model(rst, op, a, b);
    chk($sformatf("model_result rst=%0d op=%0d a=%02h b=%02h", rst, op, a, b), result, m_res);
    chk($sformatf("model_carry rst=%0d op=%0d a=%02h b=%02h", rst, op, a, b), {7'b0, carry}, {7'b0, m_c});
    chk($sformatf("model_zero rst=%0d op=%0d a=%02h b=%02h", rst, op, a, b), {7'b0, zero}, {7'b0, m_z});
  endtask

  task automatic expect_out(input string tag, input logic [7:0] r, input logic c, input logic z);
    chk({tag, "_result"}, result, r);
    chk({tag, "_carry"}, {7'b0, carry}, {7'b0, c});
    chk({tag, "_zero"}, {7'b0, zero}, {7'b0, z});
  endtask

  initial begin
    // Reset held for two clocks while an ADD is presented
    step(1'b1, 1, 8'h23, 8'h14);
    step(1'b1, 1, 8'h23, 8'h14);
    expect_out("reset", 8'h00, 1'b0, 1'b1);

    // A=00, B=FF across all ops
    for (int i = 0; i < 7; i++) begin
      step(1'b0, i + 1, 8'h00, 8'hFF);
      expect_out($sformatf("tbl1_op%0d", i + 1), t1_r[i], t1_c[i], t1_z[i]);
    end

    // A=23, B=14 across all ops
    for (int i = 0; i < 7; i++) begin
      step(1'b0, i + 1, 8'h23, 8'h14);
      expect_out($sformatf("tbl2_op%0d", i + 1), t2_r[i], 1'b0, t2_z[i]);
    end

    // Carry edge cases
    step(1'b0, 1, 8'hFF, 8'h01);
    expect_out("add_wrap", 8'h00, 1'b1, 1'b1);
    step(1'b0, 6, 8'h81, 8'h01);
    expect_out("shl_out", 8'h02, 1'b1, 1'b0);
    step(1'b0, 7, 8'h01, 8'h01);
    expect_out("shr_out", 8'h00, 1'b1, 1'b1);
    step(1'b0, 6, 8'h81, 8'hF8);
    expect_out("shl_upper_b_ignored", 8'h81, 1'b0, 1'b0);

    // NOP hold with random operand fields
    step(1'b0, 1, 8'h10, 8'h05);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      expect_out($sformatf("nop_hold%0d", i), 8'h15, 1'b0, 1'b0);
    end

    // Mid-stream one-clock reset pulse, then immediate resumption
    step(1'b0, 1, 8'hFF, 8'h01);
    step(1'b1, 2, 8'h05, 8'h03);
    expect_out("mid_reset", 8'h00, 1'b0, 1'b1);
    step(1'b0, 2, 8'h05, 8'h03);
    expect_out("after_reset", 8'h02, 1'b0, 1'b0);
    step(1'b0, 2, 8'h03, 8'h05);
    expect_out("sub_borrow", 8'hFE, 1'b1, 1'b0);

    // Randomized back-to-back stream with occasional NOPs and reset pulses
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 19) == 0, int'($urandom_range(0, 7)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
